axi_sram_bridge: RTL and testbench

- Converts the core's two SRAM-like request ports (instruction fetch, data load/store) into single-beat AXI3 master transactions.
- Sits between the pipeline's memory stages and the top-level AXI master pins.
- Allows one outstanding transaction at a time. Data port has fixed priority over instruction port.

---
 rtl/cpu_axi_pkg.sv | 29 ++
 rtl/axi_wstrb_gen.sv | 20 ++
 rtl/axi_sram_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_axi_sram_bridge.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_axi_pkg.sv
// Shared constants for the core-side SRAM-to-AXI bridge: FSM encoding,
// access sizes, default IDs, fixed AXI fields and the latched request.
package cpu_axi_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_AR   = 3'd1;
    localparam logic [2:0] ST_RD_R    = 3'd2;
    localparam logic [2:0] ST_WR_AW_W = 3'd3;
    localparam logic [2:0] ST_WR_B    = 3'd4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [3:0] INST_ID_DEF = 4'd0;
    localparam logic [3:0] DATA_ID_DEF = 4'd1;

    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef struct packed {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe for a single-beat 32-bit write from access size and
// the low address bits.
module axi_wstrb_gen
    import cpu_axi_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] wstrb_o
);

    always_comb begin
        wstrb_o = 4'b1111;
        case (size_i)
            SIZE_BYTE: wstrb_o = 4'b0001 << addr_lo_i;
            SIZE_HALF: wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            default:   wstrb_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/axi_sram_bridge.sv
// Turns the core's instruction and data SRAM-like ports into single-beat
// AXI3 transactions, one outstanding at a time, data port first.
module axi_sram_bridge
    import cpu_axi_pkg::*;
#(
    parameter logic [3:0] INST_ID = INST_ID_DEF,
    parameter logic [3:0] DATA_ID = DATA_ID_DEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    logic [2:0]  state_q, state_d;
    req_t        req_q, req_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        inst_ok_q, inst_ok_d;
    logic        data_ok_q, data_ok_d;
    logic [31:0] inst_rdata_q, inst_rdata_d;
    logic [31:0] data_rdata_q, data_rdata_d;

    // Response IDs/status and the store flag (the state already encodes it) are not consumed.
    logic unused_ok;
    assign unused_ok = ^{rid, rresp, rlast, bid, bresp, req_q.wr};

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        inst_ok_d    = 1'b0;
        data_ok_d    = 1'b0;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;

        case (state_q)
            ST_IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (data_req) begin
                    data_addr_ok = 1'b1;
                    req_d   = '{is_data: 1'b1, wr: data_wr, size: data_size,
                                addr: data_addr, wdata: data_wdata};
                    state_d = data_wr ? ST_WR_AW_W : ST_RD_AR;
                end else if (inst_req) begin
                    inst_addr_ok = 1'b1;
                    req_d   = '{is_data: 1'b0, wr: 1'b0, size: inst_size,
                                addr: inst_addr, wdata: 32'h0};
                    state_d = ST_RD_AR;
                end
            end
            ST_RD_AR: begin
                if (arready) state_d = ST_RD_R;
            end
            ST_RD_R: begin
                if (rvalid) begin
                    if (req_q.is_data) begin
                        data_rdata_d = rdata;
                        data_ok_d    = 1'b1;
                    end else begin
                        inst_rdata_d = rdata;
                        inst_ok_d    = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            ST_WR_AW_W: begin
                // Each channel may finish first or both in one cycle.
                aw_done_d = aw_done_q | (awvalid & awready);
                w_done_d  = w_done_q | (wvalid & wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = ST_WR_B;
                end
            end
            ST_WR_B: begin
                if (bvalid) begin
                    data_ok_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_q        <= '0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_ok_q    <= 1'b0;
            data_ok_q    <= 1'b0;
            inst_rdata_q <= 32'h0;
            data_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            inst_ok_q    <= inst_ok_d;
            data_ok_q    <= data_ok_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_data_ok = inst_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_data_ok = data_ok_q;
    assign data_rdata   = data_rdata_q;

    assign arid    = req_q.is_data ? DATA_ID : INST_ID;
    assign araddr  = req_q.addr;
    assign arlen   = AXI_LEN_SINGLE;
    assign arsize  = {1'b0, req_q.size};
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'h0;
    assign arprot  = 3'h0;
    assign arvalid = (state_q == ST_RD_AR);
    assign rready  = (state_q == ST_RD_R);

    assign awid    = DATA_ID;
    assign awaddr  = req_q.addr;
    assign awlen   = AXI_LEN_SINGLE;
    assign awsize  = {1'b0, req_q.size};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;
    assign awvalid = (state_q == ST_WR_AW_W) && !aw_done_q;

    assign wid     = DATA_ID;
    assign wdata   = req_q.wdata;
    assign wlast   = 1'b1;
    assign wvalid  = (state_q == ST_WR_AW_W) && !w_done_q;
    assign bready  = (state_q == ST_WR_B);

    axi_wstrb_gen u_wstrb (
        .size_i    (req_q.size),
        .addr_lo_i (req_q.addr[1:0]),
        .wstrb_o   (wstrb)
    );

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Scoreboarded bench: a delay-configurable AXI slave checks every address/data
// beat and each data_ok against expectations queued when requests are accepted.
module tb_axi_sram_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    axi_sram_bridge dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_e_t;
    typedef struct { logic [31:0] addr; logic [2:0] size; } aw_e_t;
    typedef struct { logic [31:0] data; logic [3:0] strb; } w_e_t;
    typedef struct { bit wr; logic [31:0] rdata; int acc; int lat; } d_e_t;

    ar_e_t ar_q[$];
    aw_e_t aw_q[$];
    w_e_t  w_q[$];
    d_e_t  ins_q[$];
    d_e_t  dat_q[$];

    function automatic logic [31:0] model(input logic [31:0] a);
        return (a == 32'hBFC0_0000) ? 32'h3C1D_0001 : {a[15:0] ^ 16'hA5C3, a[31:16]};
    endfunction

    function automatic logic [3:0] exp_strb(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd0: case (lo)
                2'd0:    return 4'b0001;
                2'd1:    return 4'b0010;
                2'd2:    return 4'b0100;
                default: return 4'b1000;
            endcase
            2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // slave knobs
    int ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
    bit r_hold = 0;
    int last_resp_cyc = -10;

    task automatic push_exp(input bit is_d, input bit wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd, input int lat);
        d_e_t d;
        d.wr = wr; d.rdata = wr ? 32'h0 : model(a); d.acc = cyc; d.lat = lat;
        if (wr) begin
            aw_q.push_back(aw_e_t'{a, {1'b0, sz}});
            w_q.push_back(w_e_t'{wd, exp_strb(sz, a[1:0])});
        end else begin
            ar_q.push_back(ar_e_t'{is_d ? 4'd1 : 4'd0, a, {1'b0, sz}});
        end
        if (is_d) dat_q.push_back(d); else ins_q.push_back(d);
        chk("acc_busy", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'd0);
    endtask

    task automatic issue(input bit is_d, input bit wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int lat);
        bit ok = 0;
        @(negedge clk);
        if (is_d) begin
            data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
        end else begin
            inst_req = 1; inst_size = sz; inst_addr = a;
        end
        for (int i = 0; i < 60 && !ok; i++) begin
            #1;
            if (is_d ? data_addr_ok : inst_addr_ok) begin
                ok = 1;
                push_exp(is_d, wr, sz, a, wd, lat);
            end else @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        if (is_d) data_req = 0; else inst_req = 0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100; i++) begin
            if (ar_q.size() + aw_q.size() + w_q.size() + ins_q.size() + dat_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 64'(ar_q.size() + aw_q.size() + w_q.size() + ins_q.size() + dat_q.size()), 64'd0);
        @(negedge clk);
    endtask

    // Monitor + AXI slave, evaluated once per cycle on the falling edge.
    initial begin : slave
        ar_e_t ae; aw_e_t we; w_e_t de; d_e_t e;
        int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0;
        bit r_pending = 0, b_pending = 0, aw_seen = 0, w_seen = 0;
        logic [31:0] r_addr = 32'h0;
        logic [3:0]  r_id = 4'h0;
        forever begin
            @(negedge clk);
            if (inst_data_ok) begin
                if (ins_q.size() == 0) chk("i_spurious_ok", 64'd1, 64'd0);
                else begin
                    e = ins_q.pop_front();
                    chk("i_rdata", 64'(inst_rdata), 64'(e.rdata));
                    chk("i_ok_timing", 64'(cyc), 64'(last_resp_cyc + 1));
                    if (e.lat != 0) chk("i_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (data_data_ok) begin
                if (dat_q.size() == 0) chk("d_spurious_ok", 64'd1, 64'd0);
                else begin
                    e = dat_q.pop_front();
                    if (!e.wr) chk("d_rdata", 64'(data_rdata), 64'(e.rdata));
                    chk("d_ok_timing", 64'(cyc), 64'(last_resp_cyc + 1));
                    if (e.lat != 0) chk("d_latency", 64'(cyc - e.acc), 64'(e.lat));
                end
            end
            if (rst) begin
                arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
                r_pending = 0; b_pending = 0; aw_seen = 0; w_seen = 0;
                ar_cnt = ar_delay; aw_cnt = aw_delay; w_cnt = w_delay;
            end else begin
                arready = 0;
                if (arvalid) begin
                    if (ar_cnt == 0) begin
                        arready = 1;
                        if (ar_q.size() == 0) chk("ar_spurious", 64'd1, 64'd0);
                        else begin
                            ae = ar_q.pop_front();
                            chk("araddr", 64'(araddr), 64'(ae.addr));
                            chk("arid", 64'(arid), 64'(ae.id));
                            chk("arsize", 64'(arsize), 64'(ae.size));
                            chk("ar_const", 64'({arlen, arburst, arlock, arcache, arprot}),
                                64'({4'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
                        end
                        r_addr = araddr; r_id = arid; r_pending = 1; r_cnt = r_delay;
                    end else ar_cnt--;
                end else ar_cnt = ar_delay;

                rvalid = r_hold;
                if (r_pending && rready) begin
                    if (r_cnt == 0) rvalid = 1; else r_cnt--;
                end
                rdata = model(r_addr); rid = r_id; rresp = 2'b00; rlast = 1'b1;
                if (rvalid && rready) begin r_pending = 0; last_resp_cyc = cyc; end

                awready = 0;
                if (awvalid) begin
                    if (aw_cnt == 0) begin
                        awready = 1; aw_seen = 1;
                        if (aw_q.size() == 0) chk("aw_spurious", 64'd1, 64'd0);
                        else begin
                            we = aw_q.pop_front();
                            chk("awaddr", 64'(awaddr), 64'(we.addr));
                            chk("awsize", 64'(awsize), 64'(we.size));
                            chk("aw_const", 64'({awid, awlen, awburst, awlock, awcache, awprot}),
                                64'({4'd1, 4'd0, 2'b01, 2'b00, 4'd0, 3'd0}));
                        end
                    end else aw_cnt--;
                end else aw_cnt = aw_delay;

                wready = 0;
                if (wvalid) begin
                    if (w_cnt == 0) begin
                        wready = 1; w_seen = 1;
                        if (w_q.size() == 0) chk("w_spurious", 64'd1, 64'd0);
                        else begin
                            de = w_q.pop_front();
                            chk("wdata", 64'(wdata), 64'(de.data));
                            chk("wstrb", 64'(wstrb), 64'(de.strb));
                            chk("w_const", 64'({wid, wlast}), 64'({4'd1, 1'b1}));
                        end
                    end else w_cnt--;
                end else w_cnt = w_delay;

                if (aw_seen && w_seen) begin b_pending = 1; aw_seen = 0; w_seen = 0; end
                bvalid = 0; bid = 4'd1; bresp = 2'b00;
                if (b_pending && bready) begin
                    bvalid = 1; b_pending = 0; last_resp_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        bit ok;
        inst_req = 0; inst_size = 0; inst_addr = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
        rid = 0; rdata = 0; rresp = 0; rlast = 0; bid = 0; bresp = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", 64'({arvalid, awvalid, wvalid, rready, bready}), 64'd0);
        chk("rst_oks", 64'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 64'd0);
        chk("rst_irdata", 64'(inst_rdata), 64'd0);
        chk("rst_drdata", 64'(data_rdata), 64'd0);
        @(negedge clk) rst = 0;

        // boot fetch, arready two cycles late
        ar_delay = 2;
        issue(0, 0, 2'd2, 32'hBFC0_0000, 32'h0, 5);
        wait_done();
        ar_delay = 0;

        // simultaneous requests: data load wins, fetch taken on its data_ok cycle
        @(negedge clk);
        inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 0; data_size = 2'd2; data_addr = 32'h0000_2004;
        #1;
        chk("arb_data_ok", 64'(data_addr_ok), 64'd1);
        chk("arb_inst_ok", 64'(inst_addr_ok), 64'd0);
        if (data_addr_ok) push_exp(1, 0, 2'd2, 32'h0000_2004, 32'h0, 3);
        @(posedge clk); #1 data_req = 0;
        ok = 0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk); #1;
            if (inst_addr_ok) begin
                ok = 1;
                chk("i_acc_with_dok", 64'(data_data_ok), 64'd1);
                push_exp(0, 0, 2'd2, 32'hBFC0_0004, 32'h0, 3);
            end
        end
        if (!ok) chk("i_acc_timeout", 64'd0, 64'd1);
        @(posedge clk); #1 inst_req = 0;
        wait_done();

        // store byte, wready three cycles after awready
        aw_delay = 0; w_delay = 3;
        issue(1, 1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 6);
        wait_done();

        // awready and wready in the same cycle
        aw_delay = 1; w_delay = 1;
        issue(1, 1, 2'd1, 32'h8000_0012, 32'h1234_0000, 4);
        wait_done();
        issue(1, 1, 2'd2, 32'h8000_0020, 32'hDEAD_BEEF, 4);
        wait_done();
        aw_delay = 0; w_delay = 0;
        issue(1, 1, 2'd0, 32'h8000_0041, 32'h0000_5A00, 3);
        wait_done();
        issue(1, 0, 2'd1, 32'h0000_3002, 32'h0, 3);
        wait_done();

        // reset while waiting for R: no completion, stray rvalid ignored
        r_delay = 8;
        issue(0, 0, 2'd2, 32'h0000_1000, 32'h0, 0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk); #1;
            if (rready) ok = 1;
        end
        chk("reach_rd_r", 64'(ok), 64'd1);
        rst = 1;
        ins_q.delete();
        @(negedge clk); #1;
        chk("rstmid_valids", 64'({arvalid, rready}), 64'd0);
        chk("rstmid_oks", 64'({inst_data_ok, data_data_ok}), 64'd0);
        @(negedge clk) rst = 0;
        r_delay = 0;
        r_hold = 1;
        repeat (4) begin
            @(negedge clk); #1;
            chk("stray_rvalid_ok", 64'({inst_data_ok, data_data_ok}), 64'd0);
        end
        r_hold = 0;
        issue(0, 0, 2'd2, 32'h0000_1004, 32'h0, 3);
        wait_done();

        // back-to-back loads with rvalid held high
        r_hold = 1;
        for (int k = 0; k < 4; k++)
            issue(1, 0, 2'd2, 32'h0000_4000 + 32'(k * 4), 32'h0, 3);
        wait_done();
        r_hold = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
